// File: rtl/dma_addr_gen.sv
// rtl/dma_addr_gen.sv - multi-channel DMA address generator with base/stride/limit/count
//
// Each channel holds base, stride, wrap limit and a beat budget, and advances
// on its own step pulse. All channels update in the same cycle with no priority
// between them.
//
// Ports:
//   clk_h, rst_h      clock, asynchronous active-high reset
//   clear_addr        synchronous clear of every channel (IDLE, addr=0)
//   init_addr[i]      load channel i from the latch_* slices
//   add_addr[i]       step channel i (consumed only while ACTIVE)
//   latch_base/stride/limit  per-channel AW-bit slices, latch_count CW-bit slices
//   addr_out          registered current address per channel
//   addr_valid        channel ACTIVE
//   addr_last         current address is the final beat of a bounded transfer
//   addr_done         one-cycle pulse after the final beat is consumed
//   addr_wrap         one-cycle pulse after a step wrapped to base
module dma_addr_gen #(
  parameter int NUM_CH = 3,
  parameter int AW     = 8,
  parameter int CW     = 8
) (
  input  logic                 clk_h,
  input  logic                 rst_h,
  input  logic                 clear_addr,
  input  logic [NUM_CH-1:0]    init_addr,
  input  logic [NUM_CH-1:0]    add_addr,
  input  logic [NUM_CH*AW-1:0] latch_base,
  input  logic [NUM_CH*AW-1:0] latch_stride,
  input  logic [NUM_CH*AW-1:0] latch_limit,
  input  logic [NUM_CH*CW-1:0] latch_count,
  output logic [NUM_CH*AW-1:0] addr_out,
  output logic [NUM_CH-1:0]    addr_valid,
  output logic [NUM_CH-1:0]    addr_last,
  output logic [NUM_CH-1:0]    addr_done,
  output logic [NUM_CH-1:0]    addr_wrap
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] stride_q, stride_d;
    logic [AW-1:0] limit_q, limit_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          bnd_q, bnd_d;
    logic          done_q, done_d;
    logic          wrap_q, wrap_d;
    logic [AW:0]   sum;

    // One extra bit so a step that carries out of AW still counts as
    // exceeding the limit instead of silently aliasing to a low address.
    assign sum = {1'b0, addr_q} + {1'b0, stride_q};

    always_ff @(posedge clk_h or posedge rst_h) begin
      if (rst_h) begin
        state_q  <= IDLE;
        addr_q   <= '0;
        base_q   <= '0;
        stride_q <= '0;
        limit_q  <= '0;
        rem_q    <= '0;
        bnd_q    <= 1'b0;
        done_q   <= 1'b0;
        wrap_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        addr_q   <= addr_d;
        base_q   <= base_d;
        stride_q <= stride_d;
        limit_q  <= limit_d;
        rem_q    <= rem_d;
        bnd_q    <= bnd_d;
        done_q   <= done_d;
        wrap_q   <= wrap_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      base_d   = base_q;
      stride_d = stride_q;
      limit_d  = limit_q;
      rem_d    = rem_q;
      bnd_d    = bnd_q;
      done_d   = 1'b0;
      wrap_d   = 1'b0;
      if (clear_addr) begin
        state_d = IDLE;
        addr_d  = '0;
      end else if (init_addr[i]) begin
        // Init wins over a same-cycle step and restarts an active channel.
        state_d  = ACTIVE;
        addr_d   = latch_base[i*AW +: AW];
        base_d   = latch_base[i*AW +: AW];
        stride_d = latch_stride[i*AW +: AW];
        limit_d  = latch_limit[i*AW +: AW];
        rem_d    = latch_count[i*CW +: CW];
        bnd_d    = (latch_count[i*CW +: CW] != '0);
      end else if (add_addr[i] && (state_q == ACTIVE)) begin
        if (bnd_q && (rem_q == CW'(1))) begin
          // Final beat consumed: address holds, channel stops itself.
          state_d = IDLE;
          rem_d   = '0;
          done_d  = 1'b1;
        end else begin
          if (sum > {1'b0, limit_q}) begin
            addr_d = base_q;
            wrap_d = 1'b1;
          end else begin
            addr_d = sum[AW-1:0];
          end
          if (bnd_q) rem_d = rem_q - CW'(1);
        end
      end
    end

    assign addr_out[i*AW +: AW] = addr_q;
    assign addr_valid[i]        = (state_q == ACTIVE);
    assign addr_last[i]         = (state_q == ACTIVE) && bnd_q && (rem_q == CW'(1));
    assign addr_done[i]         = done_q;
    assign addr_wrap[i]         = wrap_q;
  end

endmodule

// File: tb/tb_dma_addr_gen.sv
// tb/tb_dma_addr_gen.sv - directed-vector bench for dma_addr_gen
module tb_dma_addr_gen;

  localparam int NUM_CH = 3;
  localparam int AW     = 8;
  localparam int CW     = 8;

  logic                 clk_h = 1'b0;
  logic                 rst_h = 1'b0;
  logic                 clear_addr = 1'b0;
  logic [NUM_CH-1:0]    init_addr = '0;
  logic [NUM_CH-1:0]    add_addr = '0;
  logic [NUM_CH*AW-1:0] latch_base = '0;
  logic [NUM_CH*AW-1:0] latch_stride = '0;
  logic [NUM_CH*AW-1:0] latch_limit = '0;
  logic [NUM_CH*CW-1:0] latch_count = '0;
  logic [NUM_CH*AW-1:0] addr_out;
  logic [NUM_CH-1:0]    addr_valid;
  logic [NUM_CH-1:0]    addr_last;
  logic [NUM_CH-1:0]    addr_done;
  logic [NUM_CH-1:0]    addr_wrap;

  int n_vec = 0;
  int n_err = 0;

  dma_addr_gen #(.NUM_CH(NUM_CH), .AW(AW), .CW(CW)) dut (
    .clk_h        (clk_h),
    .rst_h        (rst_h),
    .clear_addr   (clear_addr),
    .init_addr    (init_addr),
    .add_addr     (add_addr),
    .latch_base   (latch_base),
    .latch_stride (latch_stride),
    .latch_limit  (latch_limit),
    .latch_count  (latch_count),
    .addr_out     (addr_out),
    .addr_valid   (addr_valid),
    .addr_last    (addr_last),
    .addr_done    (addr_done),
    .addr_wrap    (addr_wrap)
  );

  always #5 clk_h = ~clk_h;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  task automatic load(input int ch, input logic [7:0] b, input logic [7:0] s,
                      input logic [7:0] l, input logic [7:0] c);
    latch_base[ch*AW +: AW]   = b;
    latch_stride[ch*AW +: AW] = s;
    latch_limit[ch*AW +: AW]  = l;
    latch_count[ch*CW +: CW]  = c;
  endtask

  function automatic logic [7:0] a(input int ch);
    return addr_out[ch*AW +: AW];
  endfunction

  // Checks address plus all four status bits of one channel.
  task automatic chk_ch(input string tag, input int ch, input logic [7:0] ea,
                        input logic ev, input logic el, input logic ed, input logic ew);
    chk({tag, ".addr"},  a(ch), ea);
    chk({tag, ".valid"}, addr_valid[ch], ev);
    chk({tag, ".last"},  addr_last[ch], el);
    chk({tag, ".done"},  addr_done[ch], ed);
    chk({tag, ".wrap"},  addr_wrap[ch], ew);
  endtask

  initial begin
    #1 rst_h = 1'b1;
    tick();
    tick();
    chk("rst.addr",  addr_out, 0);
    chk("rst.valid", addr_valid, 0);
    chk("rst.last",  addr_last, 0);
    chk("rst.done",  addr_done, 0);
    chk("rst.wrap",  addr_wrap, 0);
    rst_h = 1'b0;

    // Bounded burst on ch1, add held high through and past the final beat.
    load(1, 8'h10, 8'h10, 8'h3F, 8'd3);
    init_addr = 3'b010;
    tick();
    chk_ch("b0", 1, 8'h10, 1, 0, 0, 0);
    init_addr = 3'b000;
    add_addr  = 3'b010;
    tick(); chk_ch("b1", 1, 8'h20, 1, 0, 0, 0);
    tick(); chk_ch("b2", 1, 8'h30, 1, 1, 0, 0);
    tick(); chk_ch("b3", 1, 8'h30, 0, 0, 1, 0);
    tick(); chk_ch("b4", 1, 8'h30, 0, 0, 0, 0);
    add_addr = 3'b000;

    // Unbounded wrap on ch0.
    load(0, 8'h04, 8'h04, 8'h0C, 8'd0);
    init_addr = 3'b001;
    tick(); chk_ch("w0", 0, 8'h04, 1, 0, 0, 0);
    init_addr = 3'b000;
    add_addr  = 3'b001;
    tick(); chk_ch("w1", 0, 8'h08, 1, 0, 0, 0);
    tick(); chk_ch("w2", 0, 8'h0C, 1, 0, 0, 0);
    tick(); chk_ch("w3", 0, 8'h04, 1, 0, 0, 1);
    tick(); chk_ch("w4", 0, 8'h08, 1, 0, 0, 0);
    add_addr = 3'b000;

    // Carry out of AW bits must wrap, not alias.
    load(2, 8'hF0, 8'h20, 8'hFF, 8'd0);
    init_addr = 3'b100;
    tick();
    init_addr = 3'b000;
    add_addr  = 3'b100;
    tick(); chk_ch("cw1", 2, 8'hF0, 1, 0, 0, 1);
    add_addr = 3'b000;
    tick(); chk_ch("cw2", 2, 8'hF0, 1, 0, 0, 0);

    // Init ch0 and step ch2 in the same cycle.
    load(0, 8'h40, 8'h01, 8'hFF, 8'd0);
    init_addr = 3'b001;
    add_addr  = 3'b100;
    tick();
    chk_ch("cc0", 0, 8'h40, 1, 0, 0, 0);
    chk_ch("cc2", 2, 8'hF0, 1, 0, 0, 1);
    init_addr = 3'b000;
    add_addr  = 3'b000;

    // Init and add on ch1 together: init wins, rem = count_in.
    load(1, 8'h50, 8'h08, 8'hFF, 8'd2);
    init_addr = 3'b010;
    add_addr  = 3'b010;
    tick(); chk_ch("ia0", 1, 8'h50, 1, 0, 0, 0);
    init_addr = 3'b000;
    tick(); chk_ch("ia1", 1, 8'h58, 1, 1, 0, 0);
    tick(); chk_ch("ia2", 1, 8'h58, 0, 0, 1, 0);
    // Step on an IDLE channel is ignored.
    tick(); chk_ch("idl", 1, 8'h58, 0, 0, 0, 0);
    add_addr = 3'b000;

    // Restart ch2 mid-transfer.
    load(2, 8'h00, 8'h04, 8'hFF, 8'd3);
    init_addr = 3'b100;
    tick();
    init_addr = 3'b000;
    add_addr  = 3'b100;
    tick(); chk_ch("rs0", 2, 8'h04, 1, 0, 0, 0);
    add_addr = 3'b000;
    load(2, 8'h20, 8'h04, 8'hFF, 8'd1);
    init_addr = 3'b100;
    tick(); chk_ch("rs1", 2, 8'h20, 1, 1, 0, 0);
    init_addr = 3'b000;
    add_addr  = 3'b100;
    tick(); chk_ch("rs2", 2, 8'h20, 0, 0, 1, 0);
    add_addr = 3'b000;

    // Stride 0 still counts beats.
    load(0, 8'h33, 8'h00, 8'hFF, 8'd2);
    init_addr = 3'b001;
    tick();
    init_addr = 3'b000;
    add_addr  = 3'b001;
    tick(); chk_ch("s0a", 0, 8'h33, 1, 1, 0, 0);
    tick(); chk_ch("s0b", 0, 8'h33, 0, 0, 1, 0);
    add_addr = 3'b000;

    // Limit below base: first step wraps.
    load(0, 8'h80, 8'h01, 8'h10, 8'd0);
    init_addr = 3'b001;
    tick();
    init_addr = 3'b000;
    add_addr  = 3'b001;
    tick(); chk_ch("lb", 0, 8'h80, 1, 0, 0, 1);
    add_addr = 3'b000;

    // Clear during an active burst, with a step pending.
    load(1, 8'h10, 8'h10, 8'hFF, 8'd4);
    init_addr = 3'b010;
    tick();
    init_addr = 3'b000;
    add_addr  = 3'b010;
    tick(); chk_ch("cl0", 1, 8'h20, 1, 0, 0, 0);
    clear_addr = 1'b1;
    tick();
    chk_ch("cl1", 1, 8'h00, 0, 0, 0, 0);
    chk("cl.allvalid", addr_valid, 0);
    chk("cl.alladdr",  addr_out, 0);
    clear_addr = 1'b0;
    add_addr   = 3'b000;

    // Asynchronous reset mid-burst, then init on the first edge after release.
    load(0, 8'h08, 8'h08, 8'hFF, 8'd5);
    init_addr = 3'b001;
    tick();
    init_addr = 3'b000;
    add_addr  = 3'b001;
    tick(); chk_ch("ar0", 0, 8'h10, 1, 0, 0, 0);
    #2 rst_h = 1'b1;
    #1;
    chk("ar.addr",  addr_out, 0);
    chk("ar.valid", addr_valid, 0);
    chk("ar.done",  addr_done, 0);
    #1 rst_h = 1'b0;
    add_addr = 3'b000;
    load(0, 8'h44, 8'h01, 8'hFF, 8'd0);
    init_addr = 3'b001;
    tick(); chk_ch("ar1", 0, 8'h44, 1, 0, 0, 0);
    init_addr = 3'b000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dma_addr_gen.md
# dma_addr_gen

Parametrised multi-channel address generator for the DMA path: it replaces the fixed three-pointer SDRAM/mem1/mem2 address counter. Each of NUM_CH channels holds a base, stride, wrap limit and beat budget, and channels advance independently in the same cycle. The DMA controller FSM drives init/step pulses. Per-channel valid, last, done and wrap status let the controller sequence bursts without tracking counts itself.

## Interface
- NUM_CH, 3: number of independent address channels (ch0 = SDRAM, ch1 = mem1, ch2 = mem2 in the default build).
- AW, 8: address width per channel.
- CW, 8: beat-count width per channel.

- clk_h  in  1  system clock; all state changes on the rising edge.
- rst_h  in  1  asynchronous, active-high reset.
- clear_addr  in  1  synchronous clear of all channels.
- init_addr  in  NUM_CH  per-channel load pulse.
- add_addr  in  NUM_CH  per-channel step pulse.
- latch_base  in  NUM_CH*AW  start/wrap address; channel i uses slice [i*AW +: AW].
- latch_stride  in  NUM_CH*AW  increment added per step.
- latch_limit  in  NUM_CH*AW  highest legal address before wrap.
- latch_count  in  NUM_CH*CW  beats in the transfer; 0 means unbounded.
- addr_out  out  NUM_CH*AW  current address per channel (registered).
- addr_valid  out  NUM_CH  channel is active.
- addr_last  out  NUM_CH  current address is the final beat.
- addr_done  out  NUM_CH  one-cycle pulse when the final beat is consumed.
- addr_wrap  out  NUM_CH  one-cycle pulse when a step wraps to base.

## Operation
- Per-channel registers: addr, base, stride, limit, rem (CW bits), bounded flag, valid.
- Per-channel states: IDLE (valid=0) and ACTIVE (valid=1).
- Reset (rst_h=1, asynchronous): every register in every channel is 0.
  - Outputs after reset: addr_out, addr_valid, addr_last, addr_done and addr_wrap are all 0.
- clear_addr=1 overrides all other inputs on that edge:
  - every channel goes to IDLE and addr becomes 0;
  - no done or wrap pulse is produced.
- init_addr[i], any state:
  - addr<=base_in, base<=base_in, stride<=stride_in, limit<=limit_in;
  - rem<=count_in, bounded<=(count_in!=0), valid<=1.
  - An init while ACTIVE restarts the channel; no done pulse is produced for the abandoned transfer.
- init_addr[i] and add_addr[i] in the same cycle: init wins and the step is discarded.
- add_addr[i] while IDLE: ignored; addr holds and no pulses are produced.
- add_addr[i] while ACTIVE, bounded and rem==1 (final beat consumed):
  - valid<=0, rem<=0, addr holds;
  - addr_done[i] pulses for one cycle.
- add_addr[i] while ACTIVE, any other case:
  - sum = {1'b0,addr} + {1'b0,stride}, computed at AW+1 bits;
  - if sum > {1'b0,limit}: addr<=base and addr_wrap[i] pulses; otherwise addr<=sum[AW-1:0];
  - if bounded, rem<=rem-1.
- addr_last[i] = valid & bounded & (rem==1), decoded from registers only.
- Channels are fully independent:
  - simultaneous init/add on different channels all take effect in the same cycle (no priority chain);
  - latch_* slices for channel j are sampled only when init_addr[j]=1.
- Boundary rules:
  - stride 0: addr holds while beats are still counted.
  - limit < base: the first step wraps to base.
  - Unbounded channels never assert last or done.

## Timing
- Latency: addr_out, valid and last reflect an init or step one clock after the sampling edge.
- addr_done and addr_wrap are registered pulses, high for exactly the cycle after the triggering edge.
- Back-to-back steps on every cycle are supported; throughput is 1 address per channel per cycle.
- Handshake: a step is consumed only when valid=1.
  - The controller may hold add_addr high continuously.
  - The channel stops itself after the last beat; further steps are ignored until the next init.
- Reset asserted mid-transfer: all state is cleared immediately, independent of clk_h, and no done pulse is produced.
- Reset deassertion: the first edge after deassertion may carry an init.

## Test plan
- Reset and clear:
  - assert rst_h mid-burst → all outputs 0 asynchronously;
  - separately, clear_addr during an active burst → valid=0, addr=0, no done pulse.
- Bounded burst, ch1: base=0x10, stride=0x10, limit=0x3F, count=3.
  - Drive init, then add held high → addr 0x10, 0x20, 0x30 with last high at 0x30.
  - Next edge → done pulse, valid=0, addr held at 0x30.
- Wrap, ch0: base=0x04, stride=4, limit=0x0C, count=0.
  - Drive 4 steps → addr 0x08, 0x0C, 0x04 (wrap pulse), 0x08; last and done never assert.
- Carry wrap: AW=8, base=0xF0, stride=0x20, limit=0xFF.
  - One step → sum 0x110 exceeds limit → addr=0xF0 and wrap pulses.
- Concurrency and priority:
  - init ch0 with step ch2 in the same cycle → both take effect;
  - init+add on ch1 in the same cycle → addr=base_in and rem=count_in;
  - add on an IDLE channel → no change.
- Restart: re-init ch2 while rem=2 with new base 0x20 and count 1.
  - → addr=0x20, last=1, no done pulse for the old transfer.
  - One step → done pulse.
